ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port word_ram data port. Port 0 serves the CPU data bus and port 1 serves a secondary master (DMA or debug loader). The block grants at most one access per cycle, registers read data to give a fixed 1-cycle read latency, and supports short locked bursts. A hold counter bounds the burst length so that neither master starves.

---
 rtl/ram_arbiter_pkg.sv | 18 +
 rtl/ram_arbiter_rr_grant.sv | 13 +
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port word_ram arbiter.
package ram_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StOwn0 = OWN0,
        StOwn1 = OWN1
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_grant.sv
// Two-way priority selector: a lone requester wins, on contention the port named by prio_i wins.
module rr_grant (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_i);
        gnt_o[1] = req_i[1] & (~req_i[0] |  prio_i);
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two masters onto the single word_ram port with locked bursts bounded by MAX_HOLD
// and a registered, fixed 1-cycle read return per port.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [WORD_W-1:0] m0_wdata,
    input  logic [BE_W-1:0]   m0_wenable,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [WORD_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [WORD_W-1:0] m1_wdata,
    input  logic [BE_W-1:0]   m1_wenable,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [WORD_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic [BE_W-1:0]   ram_wenable,
    input  logic [WORD_W-1:0] ram_rdata
);

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [WORD_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [1:0]          req, gnt;
    logic                eff_prio, sel, other_req, sel_lock, owner_lock;
    logic [HOLD_W-1:0]   hold_base;
    logic [HOLD_W:0]     hold_next;

    assign req = {m1_req, m0_req};

    // An owner always wins; rr_grant with prio fixed to the owner gives exactly that.
    always_comb begin
        unique case (state_q)
            StOwn0:  eff_prio = 1'b0;
            StOwn1:  eff_prio = 1'b1;
            default: eff_prio = prio_q;
        endcase
    end

    rr_grant u_rr_grant (
        .req_i  (req),
        .prio_i (eff_prio),
        .gnt_o  (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign sel    = gnt[1];

    always_comb begin
        ram_addr    = sel ? m1_addr  : m0_addr;
        ram_wdata   = sel ? m1_wdata : m0_wdata;
        ram_wenable = '0;
        if (|gnt) begin
            ram_wenable = sel ? m1_wenable : m0_wenable;
        end
    end

    always_comb begin
        other_req  = sel ? m0_req : m1_req;
        sel_lock   = sel ? m1_lock : m0_lock;
        owner_lock = (state_q == StOwn1) ? m1_lock : m0_lock;
        // A hand-over to the other port starts a fresh burst count.
        hold_base  = ((sel && state_q == StOwn1) || (!sel && state_q == StOwn0)) ? hold_q : '0;
        hold_next  = {1'b0, hold_base} + (HOLD_W+1)'(1);

        state_d = state_q;
        prio_d  = prio_q;
        hold_d  = hold_q;
        if (|gnt) begin
            prio_d = ~sel;
            if (sel_lock && (!other_req || hold_next < (HOLD_W+1)'(MAX_HOLD))) begin
                state_d = sel ? StOwn1 : StOwn0;
                hold_d  = other_req ? hold_next[HOLD_W-1:0] : hold_base;
            end else begin
                state_d = StIdle;
                hold_d  = '0;
            end
        end else if (state_q != StIdle && !owner_lock) begin
            state_d = StIdle;
            hold_d  = '0;
        end
    end

    always_comb begin
        rvalid_d[0] = gnt[0] && (m0_wenable == '0);
        rvalid_d[1] = gnt[1] && (m1_wenable == '0);
        rdata0_d    = rvalid_d[0] ? ram_rdata : rdata0_q;
        rdata1_d    = rvalid_d[1] ? ram_rdata : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            prio_q   <= 1'b0;
            hold_q   <= '0;
            rvalid_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            hold_q   <= hold_d;
            rvalid_q <= rvalid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural word_ram model on the shared port.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [14:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic [3:0]  m0_wenable;
    logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [14:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [3:0]  m1_wenable;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_wenable;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(15), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0_req      (m0_req),
        .m0_lock     (m0_lock),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_wenable  (m0_wenable),
        .m0_gnt      (m0_gnt),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_lock     (m1_lock),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_wenable  (m1_wenable),
        .m1_gnt      (m1_gnt),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_wenable (ram_wenable),
        .ram_rdata   (ram_rdata)
    );

    // word_ram model: combinational read, byte-enabled write; preload while in reset.
    logic [31:0] mem [0:255];
    assign ram_rdata = mem[ram_addr[9:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[4] <= 32'hDEADBEEF;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wenable[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_wenable = 4'h0; m0_wdata = 32'h0;
        m1_req = 0; m1_lock = 0; m1_wenable = 4'h0; m1_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        m0_addr = 15'h0044;
        m1_addr = 15'h0088;
        repeat (2) @(posedge clk);
        #3;
        check_eq("rst_m0_rvalid", m0_rvalid, 1'b0);
        check_eq("rst_m1_rvalid", m1_rvalid, 1'b0);
        check_eq("rst_m0_rdata", m0_rdata, 32'h0);
        check_eq("rst_wenable", ram_wenable, 4'h0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_no_gnt", {m1_gnt, m0_gnt}, 2'b00);
        check_eq("idle_addr_mux", ram_addr, 15'h0044);

        // Single read from port 0
        tick();
        m0_req = 1; m0_addr = 15'h0010;
        #1;
        check_eq("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
        check_eq("rd_wen", ram_wenable, 4'h0);
        tick();
        m0_req = 0;
        check_eq("rd_rvalid", m0_rvalid, 1'b1);
        check_eq("rd_rdata", m0_rdata, 32'hDEADBEEF);
        check_eq("rd_m1_quiet", m1_rvalid, 1'b0);
        tick();
        check_eq("rd_rvalid_pulse", m0_rvalid, 1'b0);
        check_eq("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

        // Round robin without lock, starting from port 0 after reset
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 15'h0010; m1_addr = 15'h0010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_gnt", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            check_eq("rr_rvalid", {m1_rvalid, m0_rvalid}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        clear_inputs();

        // Lock bound with a competing requester
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("lock_gnt", {m1_gnt, m0_gnt}, (i < 4) ? 2'b01 : 2'b10);
            tick();
        end
        clear_inputs();

        // Uncontested lock is unlimited; the bound only counts contended cycles
        do_reset();
        m0_req = 1; m0_lock = 1;
        for (int i = 0; i < 11; i++) begin
            if (i == 6) m1_req = 1;
            #1;
            check_eq("ulock_gnt", {m1_gnt, m0_gnt}, (i < 10) ? 2'b01 : 2'b10);
            tick();
        end
        clear_inputs();

        // Full write by port 1, read back by port 0, then a byte write
        m1_req = 1; m1_addr = 15'h0020; m1_wdata = 32'h12345678; m1_wenable = 4'hF;
        #1;
        check_eq("wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
        check_eq("wr_wen", ram_wenable, 4'hF);
        tick();
        m1_req = 0;
        check_eq("wr_no_rvalid", m1_rvalid, 1'b0);
        m0_req = 1; m0_addr = 15'h0020;
        #1;
        check_eq("rb_gnt", {m1_gnt, m0_gnt}, 2'b01);
        tick();
        m0_req = 0;
        check_eq("rb_rvalid", m0_rvalid, 1'b1);
        check_eq("rb_rdata", m0_rdata, 32'h12345678);
        m1_req = 1; m1_wdata = 32'h000000AA; m1_wenable = 4'h1;
        #1;
        check_eq("bw_wen", ram_wenable, 4'h1);
        tick();
        m1_req = 0; m1_wenable = 4'h0;
        m0_req = 1;
        tick();
        m0_req = 0;
        check_eq("bw_rdata", m0_rdata, 32'h123456AA);

        // Reset in the middle of a port 1 locked burst
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 15'h0020;
        #1;
        check_eq("mb_gnt", {m1_gnt, m0_gnt}, 2'b10);
        tick();
        check_eq("mb_rvalid", m1_rvalid, 1'b1);
        check_eq("mb_rdata", m1_rdata, 32'h123456AA);
        rst_n = 1'b0;
        #1;
        check_eq("mb_rvalid_clr", m1_rvalid, 1'b0);
        #1;
        rst_n = 1'b1;
        m0_req = 1; m0_addr = 15'h0010;
        #1;
        check_eq("mb_post_gnt", {m1_gnt, m0_gnt}, 2'b01);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
